// File: rtl/seq_frame_tx.sv
// seq_frame_tx: serializes a parallel payload into a "1011"-marked frame.
// Each accepted word becomes marker 1011, then the payload MSB-first with
// stuffed zeros, then IDLE_GAP zeros. The stuffing makes sure an overlapping
// "1011" detector watching x fires exactly once per frame, on the marker.
// Ports:
//   clk        - rising-edge clock
//   reset      - asynchronous, active-high reset
//   data_in    - payload word, captured only on accept
//   data_valid - payload word available
//   data_ready - registered; accept = data_valid & data_ready
//   x          - registered serial bit stream
//   busy       - high through MARK, DATA and GAP
//   done       - one-cycle pulse in the first GAP cycle
module seq_frame_tx #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned IDLE_GAP = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   output logic              data_ready,
   output logic              x,
   output logic              busy,
   output logic              done
);

   localparam int unsigned BIT_W = $clog2(DATA_W + 1);
   localparam int unsigned GAP_W = $clog2(IDLE_GAP + 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MARK = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;
   localparam logic [1:0] ST_GAP  = 2'd3;

   localparam logic [1:0] TRK_S0 = 2'd0;
   localparam logic [1:0] TRK_S1 = 2'd1;
   localparam logic [1:0] TRK_S2 = 2'd2;
   localparam logic [1:0] TRK_S3 = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [1:0]        trk_q, trk_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [BIT_W-1:0]  bits_q, bits_d;
   logic [1:0]        mark_q, mark_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic              x_q, x_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              accept_c;

   // One step of the detector's "1011" state machine.
   function automatic logic [1:0] trk_step(input logic [1:0] s, input logic b);
      logic [1:0] n;
      case (s)
         TRK_S0:  n = b ? TRK_S1 : TRK_S0;
         TRK_S1:  n = b ? TRK_S1 : TRK_S2;
         TRK_S2:  n = b ? TRK_S3 : TRK_S0;
         default: n = b ? TRK_S1 : TRK_S2;
      endcase
      return n;
   endfunction

   assign accept_c   = data_valid & ready_q;
   assign data_ready = ready_q;
   assign x          = x_q;
   assign busy       = busy_q;
   assign done       = done_q;

   // Next-slot decision: state_d/x_d describe the slot driven after the edge.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      bits_d  = bits_q;
      mark_d  = mark_q;
      gap_d   = gap_q;
      x_d     = 1'b0;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept_c) begin
               state_d = ST_MARK;
               x_d     = 1'b1;
               mark_d  = 2'd0;
               shreg_d = data_in;
               bits_d  = BIT_W'(DATA_W);
            end
         end
         ST_MARK: begin
            if (mark_q == 2'd3) begin
               // Tracker is S1 here, so the first payload bit never needs a stuff.
               state_d = ST_DATA;
               x_d     = shreg_q[DATA_W-1];
               shreg_d = shreg_q << 1;
               bits_d  = bits_q - BIT_W'(1);
            end else begin
               // Marker bits after the leading 1 are 0,1,1.
               mark_d = mark_q + 2'd1;
               x_d    = (mark_q != 2'd0);
            end
         end
         ST_DATA: begin
            if (bits_q == '0) begin
               state_d = ST_GAP;
               gap_d   = GAP_W'(1);
               done_d  = 1'b1;
            end else if (trk_q == TRK_S3) begin
               // "101" already on the line: a 0 here breaks any would-be 1011.
               x_d = 1'b0;
            end else begin
               x_d     = shreg_q[DATA_W-1];
               shreg_d = shreg_q << 1;
               bits_d  = bits_q - BIT_W'(1);
            end
         end
         default: begin
            if (gap_q == GAP_W'(IDLE_GAP)) begin
               if (accept_c) begin
                  state_d = ST_MARK;
                  x_d     = 1'b1;
                  mark_d  = 2'd0;
                  shreg_d = data_in;
                  bits_d  = BIT_W'(DATA_W);
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
      endcase

      ready_d = (state_d == ST_IDLE) ||
                ((state_d == ST_GAP) && (gap_d == GAP_W'(IDLE_GAP)));
      busy_d  = (state_d != ST_IDLE);
      trk_d   = trk_step(trk_q, x_d);
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         trk_q   <= TRK_S0;
         shreg_q <= '0;
         bits_q  <= '0;
         mark_q  <= 2'd0;
         gap_q   <= '0;
         x_q     <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         trk_q   <= trk_d;
         shreg_q <= shreg_d;
         bits_q  <= bits_d;
         mark_q  <= mark_d;
         gap_q   <= gap_d;
         x_q     <= x_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Self-checking bench for seq_frame_tx: expected frame slots are queued at
// each accept and compared slot by slot while busy; a Mealy "1011" detector
// model watches x and its z is checked against the expected marker position.
module tb_seq_frame_tx;

   localparam int unsigned GAP = 2;

   typedef struct packed {
      logic x;
      logic done;
      logic rdy;
      logic z;
   } slot_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] data_in;
   logic       data_valid;
   logic       data_ready;
   logic       x;
   logic       busy;
   logic       done;

   slot_t      exp_q[$];
   slot_t      mon_s;
   logic       z_c;
   logic [1:0] det_q = 2'd0;
   int         checks = 0;
   int         errors = 0;
   int         z_count = 0;
   int         done_count = 0;
   int         frame_count = 0;
   int         cyc = 0;

   seq_frame_tx #(.DATA_W(8), .IDLE_GAP(GAP)) dut (
      .clk        (clk),
      .reset      (reset),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .x          (x),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Slot monitor plus detector model, sampled mid-cycle.
   always @(negedge clk) begin
      if (reset) begin
         det_q = 2'd0;
      end else begin
         z_c = (det_q == 2'd3) && (x == 1'b1);
         if (z_c) z_count++;
         if (done === 1'b1) done_count++;
         if (busy === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL slot_underflow: busy=1 with no expected slot at cycle %0d", cyc);
            end else begin
               mon_s = exp_q.pop_front();
               checks++;
               if (x !== mon_s.x) begin
                  errors++; $display("FAIL slot_x: got %b want %b at cycle %0d", x, mon_s.x, cyc);
               end
               checks++;
               if (done !== mon_s.done) begin
                  errors++; $display("FAIL slot_done: got %b want %b at cycle %0d", done, mon_s.done, cyc);
               end
               checks++;
               if (data_ready !== mon_s.rdy) begin
                  errors++; $display("FAIL slot_ready: got %b want %b at cycle %0d", data_ready, mon_s.rdy, cyc);
               end
               checks++;
               if (z_c !== mon_s.z) begin
                  errors++; $display("FAIL slot_z: got %b want %b at cycle %0d", z_c, mon_s.z, cyc);
               end
            end
         end else begin
            checks++;
            if (x !== 1'b0 || done !== 1'b0 || z_c !== 1'b0) begin
               errors++;
               $display("FAIL idle_line: x=%b done=%b z=%b want 0/0/0 at cycle %0d", x, done, z_c, cyc);
            end
         end
         case (det_q)
            2'd0:    det_q = x ? 2'd1 : 2'd0;
            2'd1:    det_q = x ? 2'd1 : 2'd2;
            2'd2:    det_q = x ? 2'd3 : 2'd0;
            default: det_q = x ? 2'd1 : 2'd2;
         endcase
      end
   end

   // Reference framing: marker, payload MSB-first, 0 stuffed after any "101".
   function automatic void model(input logic [7:0] d, output logic [31:0] pat, output int n);
      logic [1:0] t;
      pat = 32'hB;
      n   = 4;
      t   = 2'd1;
      for (int i = 7; i >= 0; i--) begin
         pat = {pat[30:0], d[i]};
         n++;
         case (t)
            2'd0:    t = d[i] ? 2'd1 : 2'd0;
            2'd1:    t = d[i] ? 2'd1 : 2'd2;
            2'd2:    t = d[i] ? 2'd3 : 2'd0;
            default: t = d[i] ? 2'd1 : 2'd2;
         endcase
         if (t == 2'd3 && i != 0) begin
            pat = {pat[30:0], 1'b0};
            n++;
            t   = 2'd2;
         end
      end
   endfunction

   task automatic push_frame(input logic [31:0] pat, input int n);
      slot_t s;
      for (int i = n - 1; i >= 0; i--) begin
         s.x = pat[i]; s.done = 1'b0; s.rdy = 1'b0; s.z = (i == n - 4);
         exp_q.push_back(s);
      end
      for (int g = 0; g < int'(GAP); g++) begin
         s.x = 1'b0; s.done = (g == 0); s.rdy = (g == int'(GAP) - 1); s.z = 1'b0;
         exp_q.push_back(s);
      end
   endtask

   // Offer a word, queue its expected frame, return just after the accept edge.
   task automatic send(input logic [7:0] d, input logic [31:0] pat, input int n,
                       input bit hold, output int acc_cyc);
      int t;
      t = 0;
      data_in    = d;
      data_valid = 1'b1;
      while (data_ready !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) begin
         checks++; errors++;
         $display("FAIL accept_timeout: data_ready stayed %b", data_ready);
      end
      push_frame(pat, n);
      frame_count++;
      @(posedge clk);
      acc_cyc = cyc;
      @(negedge clk);
      if (!hold) begin
         data_valid = 1'b0;
         data_in    = ~d;
      end
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || busy !== 1'b0) && t < 100) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (t >= 100) begin
         errors++;
         $display("FAIL frame_timeout: %0d slots left busy=%b", exp_q.size(), busy);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1; data_valid = 1'b0; data_in = 8'h00;
      repeat (3) @(negedge clk);
      checks++;
      if (x !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || data_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: x=%b busy=%b done=%b ready=%b want 0000", x, busy, done, data_ready);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (data_ready !== 1'b0) begin
         errors++; $display("FAIL ready_after_release: got %b want 0", data_ready);
      end
      @(negedge clk);
      checks++;
      if (data_ready !== 1'b1) begin
         errors++; $display("FAIL ready_second_cycle: got %b want 1", data_ready);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (x !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL idle_hold: x=%b busy=%b want 0 0", x, busy);
      end
   endtask

   // Single directed frame; z and done must each fire exactly once.
   task automatic test_frame(input logic [7:0] d, input logic [31:0] pat, input int n);
      int z0, d0, a;
      z0 = z_count; d0 = done_count;
      send(d, pat, n, 1'b0, a);
      wait_idle();
      checks++;
      if (z_count - z0 != 1 || done_count - d0 != 1) begin
         errors++;
         $display("FAIL frame_%h_counts: z=%0d done=%0d want 1 1", d, z_count - z0, done_count - d0);
      end
   endtask

   task automatic test_back_to_back();
      int z0, d0, a1, a2;
      z0 = z_count; d0 = done_count;
      send(8'hB5, 32'h2EA5, 14, 1'b1, a1);
      send(8'h2D, 32'h2CA9, 14, 1'b0, a2);
      wait_idle();
      checks++;
      if (a2 - a1 != 14 + int'(GAP)) begin
         errors++; $display("FAIL b2b_spacing: got %0d cycles want %0d", a2 - a1, 14 + int'(GAP));
      end
      checks++;
      if (z_count - z0 != 2 || done_count - d0 != 2) begin
         errors++;
         $display("FAIL b2b_counts: z=%0d done=%0d want 2 2", z_count - z0, done_count - d0);
      end
   endtask

   task automatic test_abort();
      logic [31:0] pat;
      int n, a;
      model(8'h55, pat, n);
      send(8'h55, pat, n, 1'b0, a);
      repeat (6) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      checks++;
      if (x !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL abort_outputs: x=%b busy=%b done=%b want 000", x, busy, done);
      end
      exp_q.delete();
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      checks++;
      if (data_ready !== 1'b0) begin
         errors++; $display("FAIL abort_ready_release: got %b want 0", data_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (data_ready !== 1'b1) begin
         errors++; $display("FAIL abort_ready_next: got %b want 1", data_ready);
      end
      @(negedge clk);
      test_frame(8'h0F, 32'hB0F, 12);
   endtask

   task automatic test_random();
      logic [31:0] pat;
      logic [7:0]  d;
      int n, a, z0, f0, b2b;
      z0 = z_count; f0 = frame_count;
      for (int k = 0; k < 24; k++) begin
         d   = 8'($urandom);
         b2b = int'($urandom_range(0, 1));
         model(d, pat, n);
         send(d, pat, n, b2b != 0 && k != 23, a);
         if (b2b == 0) wait_idle();
      end
      data_valid = 1'b0;
      wait_idle();
      checks++;
      if (z_count - z0 != frame_count - f0) begin
         errors++;
         $display("FAIL random_z_count: got %0d want %0d", z_count - z0, frame_count - f0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_frame(8'h00, 32'hB00, 12);
      test_frame(8'hFF, 32'hBFF, 12);
      test_frame(8'hB0, 32'h2EA0, 14);
      test_frame(8'hAA, 32'h2E94, 14);
      test_back_to_back();
      test_abort();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
